down_counter_timer: RTL and testbench
=====================================

Name: down_counter_timer

Overview:
Loadable down-counting timer. It is the counterpart of the existing 8-bit up counter: it counts down instead of up and signals underflow instead of overflow. Used as a watchdog, timeout or periodic tick source beside the counter in the example designs. Supports a programmable prescaler, one-shot and auto-reload modes, and the same load/enable interface semantics as the counter.

Parameters:
WIDTH, 8, bit width of count, load_value and the reload register
PRESCALE_W, 4, bit width of the prescale divider setting

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
enable  input  1  count permission; when low, the count and prescale counter both hold
load  input  1  synchronous load strobe; has priority over everything except reset
load_value  input  WIDTH  value captured on load, into both count and reload_reg
reload_en  input  1  1 = auto-reload on underflow (periodic mode); 0 = one-shot mode
prescale  input  PRESCALE_W  one decrement every prescale+1 enabled RUN cycles
count  output  WIDTH  current count value, registered
underflow  output  1  one-cycle registered pulse when a tick occurs while count==0
busy  output  1  high while in RUN state

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): state=IDLE, count=0, reload_reg=0, pc=0, underflow=0, busy=0.
- States:
  - IDLE: entered only from reset.
  - RUN: busy=1.
  - EXPIRED: busy=0; count holds 0; enable has no effect.
- Load (any state):
  - count<=load_value, reload_reg<=load_value, pc<=0, state<=RUN, underflow<=0.
  - Visible one edge later: load high at edge N gives count==load_value after edge N.
  - Load beats a coincident tick or underflow.
  - Load held high for several cycles reloads every cycle; the last value wins.
- Tick generation:
  - Only when state==RUN and enable=1 and load=0.
  - If pc>=prescale, then tick=1 and pc<=0; otherwise pc<=pc+1.
  - The >= comparison means lowering prescale mid-count never causes a 2^PRESCALE_W wrap.
  - prescale=0 gives a tick on every enabled cycle.
  - enable=0 holds pc.
- On tick:
  - count>0: count<=count-1 (never wraps below 0). underflow<=0.
  - count==0, underflow<=1, then:
    - reload_en=1: count<=reload_reg, stay RUN.
    - reload_en=0: count stays 0, state<=EXPIRED.
- No tick: underflow<=0, so underflow is always a single-cycle pulse.
- Loading 0:
  - With reload_en=1: underflow on every tick, period prescale+1 cycles.
  - With reload_en=0: underflow at the first tick, then EXPIRED.
- Mode change: reload_en is sampled only at the underflow tick, so changing it mid-count is legal.
- Enable with no prior load: IDLE ignores enable; count stays 0 and no underflow occurs.
- Reset mid-operation: immediate return to reset values; the pending underflow is discarded.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] timer_state_e {IDLE, RUN, EXPIRED}.
  - Default WIDTH and PRESCALE_W localparams.
- One sub-module, tick_prescaler:
  - Contents: the pc register plus the >= compare.
  - Inputs: clk, rst_n, run_en, clear, prescale. Output: tick.
  - clear is driven by load.
- Top level holds the FSM, count, reload_reg and underflow registers. Target is roughly 150 to 200 lines of RTL.

Test Plan:
- One-shot, no enable: load 42 with enable=0 → count=42 after the load edge, busy=1; count is still 42 after 5 more cycles; underflow never asserts.
- One-shot countdown: prescale=0, reload_en=0, load 3, then enable=1 → count 2,1,0 on successive edges; the next edge gives a one-cycle underflow pulse, busy=0 and EXPIRED; count stays 0 with enable still high.
- Auto-reload: prescale=0, reload_en=1, load 2, enable=1 → count sequence 1,0,2,1,0,2; underflow pulses every 3 cycles; busy stays 1.
- Prescaler: prescale=3, load 5, enable=1 → count decrements every 4 cycles (5→4 after 4 enabled cycles); dropping enable for 2 cycles delays the next decrement by exactly 2 cycles.
- Load priority:
  - Load 100 while counting at 37 → count=100 at the next edge, 99 after one further tick.
  - Load 200 then 150 on consecutive cycles → 150 is captured.
  - Load asserted on the cycle count==0 would tick → no underflow pulse; count=load_value.
- Async reset mid-run: pull rst_n low between clock edges at count=17 → count=0, busy=0, underflow=0 immediately; after release, enable alone does not start counting until a load.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and default sizes for the down-counting timer
//
// Purpose: timer FSM state encoding and default parameter values used by
//          down_counter_timer and tick_prescaler.
package timer_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled run cycles down to count ticks
//
// Purpose: emits one tick every prescale+1 cycles in which run_en is high.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   run_en   - advance the divider this cycle (timer running, enabled, no load)
//   clear    - restart the divider from zero (driven by the timer load strobe)
//   prescale - divider setting; a tick every prescale+1 advancing cycles
//   tick     - combinational tick for the current cycle
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pc_q;
    logic [PRESCALE_W-1:0] pc_d;

    // Greater-or-equal rather than equality: if prescale is lowered below the
    // current phase, the next advancing cycle ticks instead of wrapping around.
    assign tick = run_en && (pc_q >= prescale);

    always_comb begin
        pc_d = pc_q;
        if (clear) begin
            pc_d = '0;
        end else if (tick) begin
            pc_d = '0;
        end else if (run_en) begin
            pc_d = pc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down-counting timer with prescaler and auto-reload
//
// Purpose: counts down from a loaded value, pulsing underflow on the tick that
//          finds the count at zero; reloads (periodic) or stops (one-shot).
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - count permission; holds count and prescaler when low
//   load       - synchronous load strobe, highest priority after reset
//   load_value - value captured into count and the reload register on load
//   reload_en  - 1: reload on underflow and keep running; 0: stop (one-shot)
//   prescale   - one decrement every prescale+1 enabled running cycles
//   count      - current count, registered
//   underflow  - single-cycle registered pulse on a tick at count zero
//   busy       - high while running
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  reload_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  underflow,
    output logic                  busy
);

    timer_state_e     state_q;
    timer_state_e     state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             underflow_q;
    logic             underflow_d;

    logic run_en;
    logic tick;

    // The divider only advances while running and not being loaded, so a load
    // can never coincide with a tick.
    assign run_en = (state_q == RUN) && enable && !load;

    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_en   (run_en),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = RUN;
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                underflow_d = 1'b1;
                if (reload_en) begin
                    count_d = reload_q;
                end else begin
                    state_d = EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign underflow = underflow_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - scoreboard testbench for down_counter_timer
module tb_down_counter_timer;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          load;
    logic [W-1:0]  load_value;
    logic          reload_en;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          underflow;
    logic          busy;

    always #5 clk = ~clk;

    down_counter_timer #(
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .reload_en  (reload_en),
        .prescale   (prescale),
        .count      (count),
        .underflow  (underflow),
        .busy       (busy)
    );

    typedef struct {
        logic [W-1:0] count;
        logic         underflow;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a timer that is either running or not, with the number
    // of enabled running cycles waited since the last tick or load.
    int m_count;
    int m_reload;
    int m_wait;
    bit m_running;
    bit m_uf;

    task automatic model_reset();
        m_count   = 0;
        m_reload  = 0;
        m_wait    = 0;
        m_running = 1'b0;
        m_uf      = 1'b0;
    endtask

    task automatic model_step(input bit ld, input int lv, input bit en, input bit ren, input int ps);
        m_uf = 1'b0;
        if (ld) begin
            m_count   = lv;
            m_reload  = lv;
            m_wait    = 0;
            m_running = 1'b1;
        end else if (m_running && en) begin
            if (m_wait < ps) begin
                m_wait = m_wait + 1;
            end else begin
                m_wait = 0;
                if (m_count > 0) begin
                    m_count = m_count - 1;
                end else begin
                    m_uf = 1'b1;
                    if (ren) m_count = m_reload;
                    else     m_running = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs ahead of the next rising edge and queue the
    // response the model predicts for that edge.
    task automatic step(input bit ld, input int lv, input bit en, input bit ren, input int ps);
        exp_t e;
        @(negedge clk);
        load       = ld;
        load_value = lv[W-1:0];
        enable     = en;
        reload_en  = ren;
        prescale   = ps[PW-1:0];
        model_step(ld, lv, en, ren, ps);
        e.count     = m_count[W-1:0];
        e.underflow = m_uf;
        e.busy      = m_running;
        sb_q.push_back(e);
    endtask

    // Directed check of the edge that follows the most recent step.
    task automatic check_now(input string name, input int c, input bit u, input bit b);
        @(posedge clk);
        #2;
        check({name, "_count"}, 32'(count), c);
        check({name, "_uf"}, 32'(underflow), 32'(u));
        check({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_count", 32'(count), 32'(e.count));
                check("sb_underflow", 32'(underflow), 32'(e.underflow));
                check("sb_busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit ren;
        int ps;
        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        load_value = '0;
        reload_en  = 1'b0;
        prescale   = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_uf", 32'(underflow), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable with no load: timer stays idle.
        repeat (3) step(0, 0, 1, 1, 0);
        check_now("idle_enable", 0, 0, 0);

        // One-shot, no enable: load holds.
        step(1, 42, 0, 0, 0);
        check_now("load42", 42, 0, 1);
        repeat (5) step(0, 0, 0, 0, 0);
        check_now("hold42", 42, 0, 1);

        // One-shot countdown to expiry.
        step(1, 3, 0, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        check_now("os_zero", 0, 0, 1);
        step(0, 0, 1, 0, 0);
        check_now("os_uf", 0, 1, 0);
        repeat (2) step(0, 0, 1, 0, 0);
        check_now("os_expired", 0, 0, 0);

        // Auto-reload: 1,0,2,1,0,2.
        step(1, 2, 1, 1, 0);
        repeat (3) step(0, 0, 1, 1, 0);
        check_now("ar_reload1", 2, 1, 1);
        repeat (3) step(0, 0, 1, 1, 0);
        check_now("ar_reload2", 2, 1, 1);

        // Prescaler of 4 with a 2-cycle enable gap.
        step(1, 5, 1, 0, 3);
        repeat (3) step(0, 0, 1, 0, 3);
        check_now("ps_before", 5, 0, 1);
        step(0, 0, 1, 0, 3);
        check_now("ps_first", 4, 0, 1);
        repeat (2) step(0, 0, 0, 0, 3);
        repeat (3) step(0, 0, 1, 0, 3);
        check_now("ps_gap_hold", 4, 0, 1);
        step(0, 0, 1, 0, 3);
        check_now("ps_gap_tick", 3, 0, 1);

        // Load priority.
        step(1, 40, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        check_now("lp_at37", 37, 0, 1);
        step(1, 100, 1, 0, 0);
        check_now("lp_load100", 100, 0, 1);
        step(0, 0, 1, 0, 0);
        check_now("lp_99", 99, 0, 1);
        step(1, 200, 1, 0, 0);
        step(1, 150, 1, 0, 0);
        check_now("lp_last_wins", 150, 0, 1);
        step(1, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 9, 1, 0, 0);
        check_now("lp_beats_uf", 9, 0, 1);

        // Asynchronous reset mid-run.
        step(1, 20, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        check("ar_pre_count", 32'(count), 17);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_rst_count", 32'(count), 0);
        check("ar_rst_uf", 32'(underflow), 0);
        check("ar_rst_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step(0, 0, 1, 0, 0);
        check_now("ar_post_idle", 0, 0, 0);

        // Randomized traffic.
        ren = 1'b0;
        ps  = 0;
        for (int i = 0; i < 2500; i++) begin
            bit ld;
            bit en;
            int lv;
            if ($urandom % 40 == 0) ren = 1'($urandom % 2);
            if ($urandom % 30 == 0) ps = ($urandom % 4 == 0) ? int'($urandom % 16) : int'($urandom % 4);
            ld = ($urandom % 12 == 0);
            lv = ($urandom % 3 == 0) ? int'($urandom % 256) : int'($urandom % 6);
            en = ($urandom % 4 != 0);
            step(ld, lv, en, ren, ps);
        end

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #3;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
